// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer between the PC/branch logic and a variable-latency
// instruction memory. Owns the PC, keeps at most one imem request outstanding,
// and hands each fetched word downstream over a valid/ready handshake. Branch
// redirects squash any in-flight or held fetch.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   br_take    redirect request, sampled every cycle
//   br_dest    redirect target, valid with br_take
//   imem_req   fetch request; held until imem_ack
//   imem_addr  fetch address (current PC)
//   imem_ack   imem_rdata valid; ignored unless imem_req=1
//   imem_rdata fetched instruction word
//   if_valid   if_ir/if_npc hold a valid instruction
//   if_ready   downstream accepts the instruction this cycle
//   if_ir      instruction word
//   if_npc     PC of that instruction + STEP
//   fetch_cnt  saturating count of delivered instructions
module fetch_ctrl #(
  parameter int unsigned           WORD     = 32,
  parameter logic [WORD-1:0]       STEP     = WORD'(1),
  parameter logic [WORD-1:0]       RESET_PC = '0,
  parameter int unsigned           CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_take,
  input  logic [WORD-1:0]  br_dest,
  output logic             imem_req,
  output logic [WORD-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [WORD-1:0]  imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WORD-1:0]  if_ir,
  output logic [WORD-1:0]  if_npc,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WORD-1:0]  pc_q,    pc_d;
  logic [WORD-1:0]  redir_q, redir_d;
  logic [WORD-1:0]  ir_q,    ir_d;
  logic [WORD-1:0]  npc_q,   npc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WORD-1:0]  pc_inc;

  // Modulo-2^WORD increment: all-ones PC wraps to zero.
  assign pc_inc = pc_q + STEP;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (br_take) pc_d = br_dest;
        state_d = REQ;
      end

      REQ: begin
        if (imem_ack) begin
          if (br_take) begin
            pc_d    = br_dest;
            state_d = REQ;
          end else begin
            ir_d    = imem_rdata;
            npc_d   = pc_inc;
            pc_d    = pc_inc;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (br_take) begin
          // The request cannot be withdrawn: pc stays on the outstanding
          // address and the new target waits in redir until the ack.
          redir_d = br_dest;
          state_d = DRAIN;
        end
      end

      HOLD: begin
        if (br_take) begin
          valid_d = 1'b0;
          pc_d    = br_dest;
          state_d = REQ;
        end else if (if_ready) begin
          valid_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = REQ;
        end
      end

      DRAIN: begin
        if (br_take) redir_d = br_dest;
        if (imem_ack) begin
          pc_d    = br_take ? br_dest : redir_q;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      ir_q    <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_ir     = ir_q;
  assign if_npc    = npc_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_take;
  logic [31:0] br_dest;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_ready;

  logic        a_req, a_valid;
  logic [31:0] a_addr, a_ir, a_npc;
  logic [15:0] a_cnt;

  logic        b_req, b_valid;
  logic [31:0] b_addr, b_ir, b_npc;
  logic [1:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.WORD(32), .STEP(32'd1), .RESET_PC(32'd0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_n), .br_take(br_take), .br_dest(br_dest),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(a_valid), .if_ready(if_ready), .if_ir(a_ir), .if_npc(a_npc), .fetch_cnt(a_cnt)
  );

  fetch_ctrl #(.WORD(32), .STEP(32'd1), .RESET_PC(32'h100), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_n), .br_take(br_take), .br_dest(br_dest),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(b_valid), .if_ready(if_ready), .if_ir(b_ir), .if_npc(b_npc), .fetch_cnt(b_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic        br;
    logic [31:0] dest;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ir;
    logic [31:0] npc;
    logic [15:0] cnt;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  function automatic vec_t mk(input logic r, input logic br, input logic [31:0] dest,
                              input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic req, input logic [31:0] addr, input logic valid,
                              input logic [31:0] ir, input logic [31:0] npc,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst_n = r;   v.br = br;     v.dest = dest;   v.ack = ack;
    v.rdata = rdata; v.ready = ready; v.req = req; v.addr = addr;
    v.valid = valid; v.ir = ir;   v.npc = npc;     v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs depend only on registered state (and async reset), so driving the
  // row's inputs and sampling 1 ns later shows this cycle's outputs.
  task automatic run_row(input vec_t v, input bit sel_b, input int idx);
    string tag;
    @(negedge clk);
    rst_n = v.rst_n; br_take = v.br; br_dest = v.dest;
    imem_ack = v.ack; imem_rdata = v.rdata; if_ready = v.ready;
    #1;
    tag = $sformatf("%s[%0d]", sel_b ? "B" : "A", idx);
    if (!sel_b) begin
      chk({tag, ".req"},   {31'd0, a_req},   {31'd0, v.req});
      chk({tag, ".addr"},  a_addr,           v.addr);
      chk({tag, ".valid"}, {31'd0, a_valid}, {31'd0, v.valid});
      chk({tag, ".ir"},    a_ir,             v.ir);
      chk({tag, ".npc"},   a_npc,            v.npc);
      chk({tag, ".cnt"},   {16'd0, a_cnt},   {16'd0, v.cnt});
    end else begin
      chk({tag, ".req"},   {31'd0, b_req},   {31'd0, v.req});
      chk({tag, ".addr"},  b_addr,           v.addr);
      chk({tag, ".valid"}, {31'd0, b_valid}, {31'd0, v.valid});
      chk({tag, ".ir"},    b_ir,             v.ir);
      chk({tag, ".npc"},   b_npc,            v.npc);
      chk({tag, ".cnt"},   {30'd0, b_cnt},   {16'd0, v.cnt});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] A0, A1, A2, A3, B4, C5, D90, GB, E0, E1, E2, E3, E4, F0;
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;
    A0 = 32'hA000_0000; A1 = 32'hA000_0001; A2 = 32'hA000_0002; A3 = 32'hA000_0003;
    B4 = 32'hB000_0004; C5 = 32'hC000_0005; D90 = 32'hD000_0090; GB = 32'hDEAD_BEEF;
    E0 = 32'hE000_0000; E1 = 32'hE000_0001; E2 = 32'hE000_0002; E3 = 32'hE000_0003;
    E4 = 32'hE000_0004; F0 = 32'hF000_0000;

    rst_n = 1'b0; br_take = 1'b0; br_dest = '0; imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;

    // rst br dest ack rdata rdy | req addr valid ir npc cnt
    // zero-wait streaming
    va.push_back(mk(0,0,0,1,0 ,1, 0,0,0,0 ,0,0));
    va.push_back(mk(1,0,0,1,A0,1, 0,0,0,0 ,0,0));
    va.push_back(mk(1,0,0,1,A0,1, 1,0,0,0 ,0,0));
    va.push_back(mk(1,0,0,1,A1,1, 0,1,1,A0,1,0));
    va.push_back(mk(1,0,0,1,A1,1, 1,1,0,A0,1,1));
    va.push_back(mk(1,0,0,1,A2,1, 0,2,1,A1,2,1));
    va.push_back(mk(1,0,0,1,A2,1, 1,2,0,A1,2,2));
    va.push_back(mk(1,0,0,1,A3,1, 0,3,1,A2,3,2));
    va.push_back(mk(1,0,0,1,A3,1, 1,3,0,A2,3,3));
    va.push_back(mk(1,0,0,0,0 ,1, 0,4,1,A3,4,3));
    // slow imem (3 wait cycles), then 5 stalled HOLD cycles
    va.push_back(mk(1,0,0,0,0 ,0, 1,4,0,A3,4,4));
    va.push_back(mk(1,0,0,0,0 ,0, 1,4,0,A3,4,4));
    va.push_back(mk(1,0,0,0,0 ,0, 1,4,0,A3,4,4));
    va.push_back(mk(1,0,0,1,B4,0, 1,4,0,A3,4,4));
    for (int i = 0; i < 5; i++) va.push_back(mk(1,0,0,1,GB,0, 0,5,1,B4,5,4));
    va.push_back(mk(1,0,0,0,0 ,1, 0,5,1,B4,5,4));
    // redirect while REQ pending at 0x5
    va.push_back(mk(1,1,32'h40,0,0 ,0, 1,5,0,B4,5,5));
    va.push_back(mk(1,0,0     ,0,0 ,0, 1,5,0,B4,5,5));
    va.push_back(mk(1,0,0     ,1,C5,0, 1,5,0,B4,5,5));
    // two redirects before ack: latest wins
    va.push_back(mk(1,1,32'h80,0,0 ,0, 1,32'h40,0,B4,5,5));
    va.push_back(mk(1,1,32'h90,0,0 ,0, 1,32'h40,0,B4,5,5));
    va.push_back(mk(1,0,0     ,1,C5,0, 1,32'h40,0,B4,5,5));
    va.push_back(mk(1,0,0     ,1,D90,0, 1,32'h90,0,B4,5,5));
    // squash in HOLD with if_ready=1
    va.push_back(mk(1,1,32'h20,0,0 ,1, 0,32'h91,1,D90,32'h91,5));
    // ack & br_take in REQ
    va.push_back(mk(1,1,32'h30,1,C5,0, 1,32'h20,0,D90,32'h91,5));
    // ack & br_take in DRAIN: br_dest beats stored target
    va.push_back(mk(1,1,32'h50,0,0 ,0, 1,32'h30,0,D90,32'h91,5));
    va.push_back(mk(1,1,32'h60,1,C5,0, 1,32'h30,0,D90,32'h91,5));
    va.push_back(mk(1,0,0     ,0,0 ,0, 1,32'h60,0,D90,32'h91,5));
    // reset mid-REQ, then redirect from IDLE
    va.push_back(mk(0,0,0     ,1,C5,1, 0,0,0,0,0,0));
    va.push_back(mk(1,1,32'h70,0,0 ,0, 0,0,0,0,0,0));
    va.push_back(mk(1,0,0     ,0,0 ,0, 1,32'h70,0,0,0,0));

    // RESET_PC=0x100, CNT_W=2
    vb.push_back(mk(0,0,0,1,0 ,1, 0,32'h100,0,0 ,0,0));
    vb.push_back(mk(1,0,0,1,E0,1, 0,32'h100,0,0 ,0,0));
    vb.push_back(mk(1,0,0,1,E0,1, 1,32'h100,0,0 ,0,0));
    vb.push_back(mk(1,0,0,1,E1,1, 0,32'h101,1,E0,32'h101,0));
    vb.push_back(mk(1,0,0,1,E1,1, 1,32'h101,0,E0,32'h101,1));
    vb.push_back(mk(1,0,0,1,E2,1, 0,32'h102,1,E1,32'h102,1));
    vb.push_back(mk(1,0,0,1,E2,1, 1,32'h102,0,E1,32'h102,2));
    vb.push_back(mk(1,0,0,1,E3,1, 0,32'h103,1,E2,32'h103,2));
    vb.push_back(mk(1,0,0,1,E3,1, 1,32'h103,0,E2,32'h103,3));
    vb.push_back(mk(1,0,0,1,E4,1, 0,32'h104,1,E3,32'h104,3));
    vb.push_back(mk(1,0,0,1,E4,0, 1,32'h104,0,E3,32'h104,3));
    vb.push_back(mk(1,0,0,0,0 ,0, 0,32'h105,1,E4,32'h105,3));
    vb.push_back(mk(0,0,0,0,0 ,0, 0,32'h100,0,0 ,0,0));
    vb.push_back(mk(1,0,0,0,0 ,0, 0,32'h100,0,0 ,0,0));
    vb.push_back(mk(1,0,0,0,0 ,0, 1,32'h100,0,0 ,0,0));
    vb.push_back(mk(0,0,0,1,E0,0, 0,32'h100,0,0 ,0,0));
    vb.push_back(mk(1,1,32'hFFFF_FFFF,0,0,0, 0,32'h100,0,0,0,0));
    vb.push_back(mk(1,0,0,1,F0,0, 1,32'hFFFF_FFFF,0,0,0,0));
    vb.push_back(mk(1,0,0,0,0 ,1, 0,0,1,F0,0,0));
    vb.push_back(mk(1,0,0,0,0 ,0, 1,0,0,F0,0,1));

    foreach (va[i]) run_row(va[i], 1'b0, i);

    // Varying ack latency on dut_a, now in REQ at 0x70: request and address
    // must hold through every wait cycle, and the word appears one cycle after ack.
    exp_pc  = 32'h70;
    exp_cnt = 16'd0;
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d <= k; d++) begin
        @(negedge clk);
        rst_n = 1'b1; br_take = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
        #1;
        chk($sformatf("S%0d.wait%0d.req", k, d),  {31'd0, a_req}, 32'd1);
        chk($sformatf("S%0d.wait%0d.addr", k, d), a_addr, exp_pc);
      end
      @(negedge clk);
      imem_ack = 1'b1; imem_rdata = 32'h5A00 + k;
      #1;
      chk($sformatf("S%0d.ack.valid", k), {31'd0, a_valid}, 32'd0);
      @(negedge clk);
      imem_ack = 1'b0; if_ready = 1'b1;
      #1;
      chk($sformatf("S%0d.valid", k), {31'd0, a_valid}, 32'd1);
      chk($sformatf("S%0d.ir", k),    a_ir,  32'h5A00 + k);
      chk($sformatf("S%0d.npc", k),   a_npc, exp_pc + 32'd1);
      chk($sformatf("S%0d.cnt", k),   {16'd0, a_cnt}, {16'd0, exp_cnt});
      exp_pc  = exp_pc + 32'd1;
      exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clk);
    if_ready = 1'b0;
    #1;
    chk("S.final_cnt",  {16'd0, a_cnt}, {16'd0, exp_cnt});
    chk("S.final_addr", a_addr, exp_pc);

    foreach (vb[i]) run_row(vb[i], 1'b1, i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
